// File: rtl/sisc_pkg.sv
// Shared SISC definitions: opcode constants, datapath width defaults and fetch state encoding.
package sisc_pkg;

  localparam int unsigned PC_W_DEF = 16;
  localparam int unsigned IR_W_DEF = 32;

  typedef logic [3:0] opcode_t;

  localparam opcode_t OP_NOOP   = 4'd0;
  localparam opcode_t OP_LOD    = 4'd1;
  localparam opcode_t OP_STR    = 4'd2;
  localparam opcode_t OP_SWP    = 4'd3;
  localparam opcode_t OP_BRA    = 4'd4;
  localparam opcode_t OP_BRR    = 4'd5;
  localparam opcode_t OP_BNE    = 4'd6;
  localparam opcode_t OP_BNR    = 4'd7;
  localparam opcode_t OP_ALU_OP = 4'd8;
  localparam opcode_t OP_HLT    = 4'd15;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t ST_IDLE = 2'd0;
  localparam fetch_state_t ST_WAIT = 2'd1;
  localparam fetch_state_t ST_PREF = 2'd2;

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter register: clear, relative/absolute branch and increment, all wrapping at PC_W bits.
module pc_reg
  import sisc_pkg::*;
#(
  parameter int unsigned PC_W = PC_W_DEF
) (
  input  logic            clk,
  input  logic            rst_f,
  input  logic            clr,
  input  logic            inc,
  input  logic            br,
  input  logic            br_abs,
  input  logic [PC_W-1:0] br_off,
  output logic [PC_W-1:0] pc
);

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      pc <= '0;
    end else if (clr) begin
      pc <= '0;
    end else if (br) begin
      pc <= br_abs ? br_off : pc + br_off;
    end else if (inc) begin
      pc <= pc + PC_W'(1);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// SISC instruction-fetch stage: PC/IR, imem req/ack handshake, controller PC commands.
// Optional one-entry prefetch buffer enabled by defining FETCH_PREFETCH_EN.
module fetch_unit
  import sisc_pkg::*;
#(
  parameter int unsigned PC_W = PC_W_DEF,
  parameter int unsigned IR_W = IR_W_DEF
) (
  input  logic            clk,
  input  logic            rst_f,
  input  logic            ir_load,
  input  logic            pc_write,
  input  logic            pc_sel,
  input  logic            br_sel,
  input  logic            pc_rst,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [IR_W-1:0] imem_rdata,
  output logic [PC_W-1:0] pc,
  output logic [IR_W-1:0] ir,
  output logic [3:0]      opcode,
  output logic [3:0]      mm,
  output logic            fetch_stall
);

  fetch_state_t    state;
  logic            inc_pend;
  logic            cmd_inc;
  logic            cmd_br;
  logic            pc_inc;
  logic            pc_br;
  logic [PC_W-1:0] br_off;

  assign cmd_inc     = pc_write & ~pc_sel;
  assign cmd_br      = pc_write & pc_sel;
  assign br_off      = PC_W'(ir[15:0]);
  assign opcode      = ir[IR_W-1 -: 4];
  assign mm          = ir[IR_W-5 -: 4];
  assign fetch_stall = (state == ST_WAIT);

`ifdef FETCH_PREFETCH_EN
  logic [IR_W-1:0] pf_data;
  logic [PC_W-1:0] pf_addr;
  logic            pf_valid;
  logic            pf_want;   // a demand fetch just finished; prefetch the new pc
  logic            pf_drop;   // in-flight prefetch response must be discarded
  logic            dem_pend;  // demand fetch queued behind a stale prefetch
  logic            pf_hit;
  logic            pref_match;
  logic [PC_W-1:0] pc_next;

  assign pf_hit     = pf_valid && (pf_addr == pc);
  assign pref_match = (imem_addr == pc) && !pf_drop;
  assign pc_next    = cmd_inc ? pc + PC_W'(1) : pc;
`endif

  always_comb begin
    pc_inc = 1'b0;
    pc_br  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!ir_load) begin
          pc_inc = cmd_inc;
          pc_br  = cmd_br;
        end
`ifdef FETCH_PREFETCH_EN
        else if (pf_hit) begin
          pc_inc = cmd_inc;
        end
`endif
      end
      ST_WAIT: pc_inc = imem_ack & inc_pend;
`ifdef FETCH_PREFETCH_EN
      ST_PREF: begin
        if (!dem_pend) begin
          if (!ir_load) begin
            pc_inc = cmd_inc;
            pc_br  = cmd_br;
          end else if (pref_match && imem_ack) begin
            pc_inc = cmd_inc;
          end
        end
      end
`endif
      default: ;
    endcase
  end

  pc_reg #(
    .PC_W(PC_W)
  ) u_pc_reg (
    .clk    (clk),
    .rst_f  (rst_f),
    .clr    (pc_rst),
    .inc    (pc_inc),
    .br     (pc_br),
    .br_abs (br_sel),
    .br_off (br_off),
    .pc     (pc)
  );

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state     <= ST_IDLE;
      imem_req  <= 1'b0;
      imem_addr <= '0;
      ir        <= '0;
      inc_pend  <= 1'b0;
`ifdef FETCH_PREFETCH_EN
      pf_data   <= '0;
      pf_addr   <= '0;
      pf_valid  <= 1'b0;
      pf_want   <= 1'b0;
      pf_drop   <= 1'b0;
      dem_pend  <= 1'b0;
`endif
    end else if (pc_rst) begin
      // Abandons any outstanding access; a coincident ack is discarded.
      state    <= ST_IDLE;
      imem_req <= 1'b0;
      inc_pend <= 1'b0;
`ifdef FETCH_PREFETCH_EN
      pf_valid <= 1'b0;
      pf_want  <= 1'b0;
      pf_drop  <= 1'b0;
      dem_pend <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
`ifdef FETCH_PREFETCH_EN
          if (ir_load && pf_hit) begin
            ir        <= pf_data;
            pf_valid  <= 1'b0;
            pf_want   <= 1'b0;
            imem_addr <= pc_next;
            imem_req  <= 1'b1;
            state     <= ST_PREF;
          end else if (ir_load) begin
            imem_addr <= pc;
            imem_req  <= 1'b1;
            inc_pend  <= cmd_inc;
            state     <= ST_WAIT;
          end else if (cmd_br) begin
            pf_valid <= 1'b0;
            pf_want  <= 1'b0;
          end else if (pf_want) begin
            imem_addr <= pc_next;
            imem_req  <= 1'b1;
            pf_want   <= 1'b0;
            state     <= ST_PREF;
          end
`else
          if (ir_load) begin
            imem_addr <= pc;
            imem_req  <= 1'b1;
            inc_pend  <= cmd_inc;
            state     <= ST_WAIT;
          end
`endif
        end
        ST_WAIT: begin
          if (imem_ack) begin
            ir       <= imem_rdata;
            imem_req <= 1'b0;
            state    <= ST_IDLE;
`ifdef FETCH_PREFETCH_EN
            pf_want  <= 1'b1;
`endif
          end
        end
`ifdef FETCH_PREFETCH_EN
        ST_PREF: begin
          if (dem_pend) begin
            // Stale prefetch retired; reissue the held request as a demand fetch of pc.
            if (imem_ack) begin
              imem_addr <= pc;
              pf_drop   <= 1'b0;
              dem_pend  <= 1'b0;
              state     <= ST_WAIT;
            end
          end else if (ir_load) begin
            inc_pend <= cmd_inc;
            if (pref_match) begin
              if (imem_ack) begin
                ir       <= imem_rdata;
                imem_req <= 1'b0;
                pf_want  <= 1'b1;
                state    <= ST_IDLE;
              end else begin
                state <= ST_WAIT;
              end
            end else if (imem_ack) begin
              imem_addr <= pc;
              pf_drop   <= 1'b0;
              state     <= ST_WAIT;
            end else begin
              pf_drop  <= 1'b1;
              dem_pend <= 1'b1;
            end
          end else if (imem_ack) begin
            if (!pf_drop && !cmd_br) begin
              pf_data  <= imem_rdata;
              pf_addr  <= imem_addr;
              pf_valid <= 1'b1;
            end else begin
              pf_valid <= 1'b0;
            end
            pf_drop  <= 1'b0;
            imem_req <= 1'b0;
            state    <= ST_IDLE;
          end else if (cmd_br) begin
            pf_drop  <= 1'b1;
            pf_valid <= 1'b0;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
